// File: rtl/motoro3_step_sequencer.sv
// 12-step commutation sequencer for the 3-phase PWM path: owns step timing, the
// boundary strobes and the weighted per-step position increment (falling-edge logic).
module motoro3_step_sequencer (
  input  logic        clk,
  input  logic        nRst,
  input  logic        m3r_start,
  input  logic        m3r_dir,
  input  logic [3:0]  m3r_startStep,
  input  logic [24:0] m3r_stepPeriod,
  input  logic [15:0] m3r_posBase,
  output logic        pwmActive1,
  output logic [3:0]  sgStep,
  output logic [24:0] m3cnt,
  output logic        m3cntFirst2,
  output logic        m3cntFirst1,
  output logic        m3cntLast2,
  output logic        m3cntLast1,
  output logic [15:0] pwmLENpos,
  output logic [15:0] stepRound
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [24:0] pReg;
  logic [15:0] baseReg;
  logic        dirReg;

  logic        active;
  logic        lastStep;
  logic        startLoad;
  logic        goIdle;
  logic [3:0]  startStepClamped;
  logic [3:0]  stepNext;
  logic        stepWrap;

  // Weight {8,12,16,16,12,8} by step mod 6; the 21-bit product is scaled by 1/16.
  function automatic logic [15:0] shapePos(input logic [3:0] step, input logic [15:0] base);
    logic [4:0]  weight;
    logic [20:0] product;
    case (step)
      4'd0, 4'd5, 4'd6, 4'd11: weight = 5'd8;
      4'd1, 4'd4, 4'd7, 4'd10: weight = 5'd12;
      default:                 weight = 5'd16;
    endcase
    product = {5'd0, base} * {16'd0, weight};
    return (product > 21'h0F_FFFF) ? 16'hFFFF : 16'(product >> 4);
  endfunction

  function automatic logic [24:0] clampPeriod(input logic [24:0] period);
    return (period < 25'd4) ? 25'd4 : period;
  endfunction

  assign active           = (state != IDLE);
  assign lastStep         = active && (m3cnt == pReg - 25'd1);
  assign startLoad        = (state == IDLE) && m3r_start;
  assign goIdle           = lastStep && (stateNext == IDLE);
  assign startStepClamped = (m3r_startStep > 4'd11) ? 4'd0 : m3r_startStep;

  assign pwmActive1  = active;
  assign m3cntFirst2 = active && (m3cnt == 25'd0);
  assign m3cntFirst1 = active && (m3cnt == 25'd1);
  assign m3cntLast2  = active && (m3cnt == pReg - 25'd2);
  assign m3cntLast1  = lastStep;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (m3r_start) stateNext = RUN;
      RUN:       if (!m3r_start) stateNext = STOP_PEND;
      STOP_PEND: begin
        if (m3r_start)     stateNext = RUN;
        else if (lastStep) stateNext = IDLE;
      end
      default:   stateNext = IDLE;
    endcase
  end

  always_comb begin
    stepNext = sgStep;
    stepWrap = 1'b0;
    if (dirReg) begin
      if (sgStep == 4'd0) begin
        stepNext = 4'd11;
        stepWrap = 1'b1;
      end else begin
        stepNext = sgStep - 4'd1;
      end
    end else if (sgStep >= 4'd11) begin
      stepNext = 4'd0;
      stepWrap = 1'b1;
    end else begin
      stepNext = sgStep + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      sgStep    <= 4'd0;
      m3cnt     <= 25'd0;
      pwmLENpos <= 16'd0;
      stepRound <= 16'd0;
      pReg      <= 25'd4;
      baseReg   <= 16'd0;
      dirReg    <= 1'b0;
    end else if (startLoad) begin
      sgStep    <= startStepClamped;
      m3cnt     <= 25'd0;
      pReg      <= clampPeriod(m3r_stepPeriod);
      baseReg   <= m3r_posBase;
      dirReg    <= m3r_dir;
      pwmLENpos <= shapePos(startStepClamped, m3r_posBase);
    end else if (goIdle) begin
      m3cnt     <= 25'd0;
      pwmLENpos <= 16'd0;
    end else if (lastStep) begin
      // Step boundary: next step's period, base and direction are sampled here.
      m3cnt     <= 25'd0;
      sgStep    <= stepNext;
      pReg      <= clampPeriod(m3r_stepPeriod);
      baseReg   <= m3r_posBase;
      dirReg    <= m3r_dir;
      pwmLENpos <= shapePos(stepNext, m3r_posBase);
      if (stepWrap) stepRound <= stepRound + 16'd1;
    end else if (active) begin
      m3cnt <= m3cnt + 25'd1;
    end
  end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Scoreboard bench for motoro3_step_sequencer: a step-level model pushes one record
// per expected step; a monitor checks every active and idle cycle against it.
module tb_motoro3_step_sequencer;

  logic        clk = 1'b0;
  logic        nRst = 1'b1;
  logic        m3r_start = 1'b0;
  logic        m3r_dir = 1'b0;
  logic [3:0]  m3r_startStep = 4'd0;
  logic [24:0] m3r_stepPeriod = 25'd4;
  logic [15:0] m3r_posBase = 16'd0;
  logic        pwmActive1;
  logic [3:0]  sgStep;
  logic [24:0] m3cnt;
  logic        m3cntFirst2;
  logic        m3cntFirst1;
  logic        m3cntLast2;
  logic        m3cntLast1;
  logic [15:0] pwmLENpos;
  logic [15:0] stepRound;

  motoro3_step_sequencer dut (
    .clk            (clk),
    .nRst           (nRst),
    .m3r_start      (m3r_start),
    .m3r_dir        (m3r_dir),
    .m3r_startStep  (m3r_startStep),
    .m3r_stepPeriod (m3r_stepPeriod),
    .m3r_posBase    (m3r_posBase),
    .pwmActive1     (pwmActive1),
    .sgStep         (sgStep),
    .m3cnt          (m3cnt),
    .m3cntFirst2    (m3cntFirst2),
    .m3cntFirst1    (m3cntFirst1),
    .m3cntLast2     (m3cntLast2),
    .m3cntLast1     (m3cntLast1),
    .pwmLENpos      (pwmLENpos),
    .stepRound      (stepRound)
  );

  always #50 clk = ~clk;

  typedef struct {
    int step;
    int pos;
    int len;
    int round;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   mStep = 0;
  int   mP = 4;
  int   mBase = 0;
  int   mDir = 0;
  int   mRound = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int model_pos(input int step, input int base);
    int w[6] = '{8, 12, 16, 16, 12, 8};
    int v;
    v = (base * w[step % 6]) / 16;
    if (v > 65535) v = 65535;
    return v;
  endfunction

  task automatic push_step();
    rec_t r;
    r.step  = mStep;
    r.pos   = model_pos(mStep, mBase);
    r.len   = mP;
    r.round = mRound;
    q.push_back(r);
  endtask

  // Called just after a posedge while idle; the DUT starts on the following falling edge.
  task automatic start_run(input int ss, input int p, input int b, input int d);
    m3r_startStep  = 4'(ss);
    m3r_stepPeriod = 25'(p);
    m3r_posBase    = 16'(b);
    m3r_dir        = 1'(d);
    m3r_start      = 1'b1;
    mStep = (ss > 11) ? 0 : ss;
    mP    = (p < 4) ? 4 : p;
    mBase = b;
    mDir  = d;
    push_step();
  endtask

  // Plays out the current step; inputs for the next boundary change at posedge 'at' of the step.
  task automatic run_step(input int nP, input int nB, input int nD,
                          input bit keep, input bit bounce, input int at);
    int len;
    int a;
    len = mP;
    a   = at;
    if (a == 0) a = bounce ? int'($urandom_range(1, len - 2)) : int'($urandom_range(1, len - 1));
    for (int j = 1; j <= len; j++) begin
      @(posedge clk);
      if (j == a) begin
        m3r_stepPeriod = 25'(nP);
        m3r_posBase    = 16'(nB);
        m3r_dir        = 1'(nD);
        if (!keep || bounce) m3r_start = 1'b0;
      end
      if (bounce && j == a + 1) m3r_start = 1'b1;
    end
    if (keep) begin
      if (mDir != 0) begin
        if (mStep == 0) mRound = (mRound + 1) % 65536;
        mStep = (mStep + 11) % 12;
      end else begin
        if (mStep == 11) mRound = (mRound + 1) % 65536;
        mStep = (mStep + 1) % 12;
      end
      mP    = (nP < 4) ? 4 : nP;
      mBase = nB;
      mDir  = nD;
      push_step();
    end else begin
      @(posedge clk);
      check("stop_active", 32'(pwmActive1), 32'd0);
      check("stop_sgStep_held", 32'(sgStep), 32'(mStep));
      check("stop_stepRound_held", 32'(stepRound), 32'(mRound));
      check("stop_m3cnt", 32'(m3cnt), 32'd0);
      check("stop_pwmLENpos", 32'(pwmLENpos), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_active"}, 32'(pwmActive1), 32'd0);
    check({tag, "_sgStep"}, 32'(sgStep), 32'd0);
    check({tag, "_m3cnt"}, 32'(m3cnt), 32'd0);
    check({tag, "_strobes"}, 32'({m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1}), 32'd0);
    check({tag, "_pwmLENpos"}, 32'(pwmLENpos), 32'd0);
    check({tag, "_stepRound"}, 32'(stepRound), 32'd0);
  endtask

  // Monitor: compares every sampled cycle against the front step record.
  initial begin
    int   idx;
    rec_t cur;
    idx = 0;
    forever begin
      @(posedge clk);
      if (!nRst) begin
        idx = 0;
      end else if (pwmActive1) begin
        if (q.size() == 0) begin
          check("unexpected_active_cycle", 32'd0, 32'd1);
        end else begin
          cur = q[0];
          check("m3cnt", 32'(m3cnt), 32'(idx));
          check("sgStep", 32'(sgStep), 32'(cur.step));
          check("pwmLENpos", 32'(pwmLENpos), 32'(cur.pos));
          check("stepRound", 32'(stepRound), 32'(cur.round));
          check("strobes_F2F1L2L1", 32'({m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1}),
                32'({idx == 0, idx == 1, idx == cur.len - 2, idx == cur.len - 1}));
          if (idx == cur.len - 1) begin
            void'(q.pop_front());
            idx = 0;
          end else begin
            idx++;
          end
        end
      end else begin
        check("no_partial_step", 32'(idx), 32'd0);
        check("idle_m3cnt", 32'(m3cnt), 32'd0);
        check("idle_pwmLENpos", 32'(pwmLENpos), 32'd0);
        check("idle_strobes", 32'({m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1}), 32'd0);
      end
    end
  end

  initial begin
    int nSteps;
    #5 nRst = 1'b0;
    #10 check_reset_outputs("reset");
    @(posedge clk);
    #10 nRst = 1'b1;
    @(posedge clk);

    // Forward run, P=10, base 100: a full revolution plus one step.
    start_run(0, 10, 100, 0);
    for (int s = 0; s < 13; s++) run_step(10, 100, 0, 1'b1, 1'b0, 0);
    // P=2 clamps to 4-clock steps.
    for (int s = 0; s < 3; s++) run_step(2, 100, 0, 1'b1, 1'b0, 0);
    // Mid-step change to 20: only the following step is 20 long.
    run_step(20, 100, 0, 1'b1, 1'b0, 2);
    run_step(20, 100, 0, 1'b1, 1'b1, 0);
    run_step(20, 100, 0, 1'b0, 1'b0, 0);

    // Stop requested at m3cnt=3: the step completes before going idle.
    start_run(0, 10, 100, 0);
    run_step(10, 100, 0, 1'b1, 1'b0, 0);
    run_step(10, 100, 0, 1'b0, 1'b0, 4);

    // Reverse from step 1 with a large base: 1, 0, 11, 10, 9.
    start_run(1, 10, 16'hF000, 1);
    for (int s = 0; s < 4; s++) run_step(10, 16'hF000, 1, 1'b1, 1'b0, 0);
    run_step(10, 16'hF000, 1, 1'b0, 1'b0, 0);

    // Randomized runs with start-step clamping, stop bounces and direction flips.
    for (int r = 0; r < 6; r++) begin
      start_run(int'($urandom_range(0, 15)), int'($urandom_range(0, 14)),
                int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)));
      nSteps = int'($urandom_range(2, 7));
      for (int s = 0; s < nSteps; s++)
        run_step(int'($urandom_range(0, 14)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 1)), 1'b1, ($urandom_range(0, 3) == 0), 0);
      run_step(int'($urandom_range(0, 14)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 1)), 1'b0, 1'b0, 0);
    end

    // Asynchronous reset at m3cnt=5 mid-step.
    start_run(3, 10, 1234, 0);
    for (int j = 1; j <= 6; j++) @(posedge clk);
    #10;
    nRst = 1'b0;
    m3r_start = 1'b0;
    q.delete();
    #5 check_reset_outputs("async_reset");
    mStep = 0; mRound = 0; mP = 4; mBase = 0; mDir = 0;
    @(posedge clk);
    #10 nRst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    check("post_reset_idle", 32'(pwmActive1), 32'd0);

    // Degenerate P=4 run after reset.
    start_run(11, 4, 16'hFFFF, 0);
    run_step(4, 16'hFFFF, 0, 1'b1, 1'b0, 0);
    run_step(4, 16'hFFFF, 0, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
